// File: rtl/video_pattern_gen.sv
// rtl/video_pattern_gen.sv - registered four-mode video test-pattern generator
// Mode, scroll counter and bouncing-box state only change on frame_start.
module video_pattern_gen #(
   parameter  int HOR_ACTIVE_PIXELS = 640,
   parameter  int VER_ACTIVE_PIXELS = 480,
   parameter  int BOX_SIZE          = 32,
   parameter  int BOX_STEP          = 2,
   parameter  int CHECKER_LOG2      = 5,
   localparam int X_WIDTH           = $clog2(HOR_ACTIVE_PIXELS),
   localparam int Y_WIDTH           = $clog2(VER_ACTIVE_PIXELS)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [X_WIDTH-1:0] x,
   input  logic [Y_WIDTH-1:0] y,
   input  logic               de,
   input  logic               frame_start,
   input  logic [1:0]         mode_sel,
   output logic [7:0]         r,
   output logic [7:0]         g,
   output logic [7:0]         b,
   output logic               de_out,
   output logic [1:0]         mode
);

   localparam int PW  = X_WIDTH + Y_WIDTH;
   localparam int BW  = X_WIDTH + 3;
   localparam int XW1 = X_WIDTH + 1;
   localparam int YW1 = Y_WIDTH + 1;

   typedef enum logic [1:0] {
      MODE_BORDER  = 2'd0,
      MODE_BARS    = 2'd1,
      MODE_CHECKER = 2'd2,
      MODE_BOX     = 2'd3
   } mode_e;

   mode_e              mode_q, mode_d;
   logic [X_WIDTH-1:0] frame_cnt_q, frame_cnt_d;
   logic [X_WIDTH-1:0] box_x_q, box_x_d;
   logic [Y_WIDTH-1:0] box_y_q, box_y_d;
   logic               dir_x_q, dir_x_d;
   logic               dir_y_q, dir_y_d;
   logic [7:0]         r_q, r_d, g_q, g_d, b_q, b_d;
   logic               de_q;

   logic [PW-1:0]      x_wide, y_wide, diag_down, diag_up;
   logic               on_line;
   logic [2:0]         bar_idx;
   logic               checker_c;
   logic               in_box;
   logic [XW1-1:0]     box_nx;
   logic [YW1-1:0]     box_ny;

   // Mode 0: frame border plus both diagonals, full-width integer math.
   assign x_wide    = PW'(x);
   assign y_wide    = PW'(y);
   assign diag_down = (x_wide * PW'(VER_ACTIVE_PIXELS)) / PW'(HOR_ACTIVE_PIXELS);
   assign diag_up   = PW'(VER_ACTIVE_PIXELS) - diag_down;
   assign on_line   = (x == '0) || (x == X_WIDTH'(HOR_ACTIVE_PIXELS - 1)) ||
                      (y == '0) || (y == Y_WIDTH'(VER_ACTIVE_PIXELS - 1)) ||
                      (y_wide == diag_down) || (y_wide == diag_up);

   assign bar_idx   = 3'({x, 3'b000} / BW'(HOR_ACTIVE_PIXELS));

   // Column sum wraps at 2^X_WIDTH, which makes the checker scroll left.
   assign checker_c = 1'((x + frame_cnt_q) >> CHECKER_LOG2) ^ y[CHECKER_LOG2];

   assign in_box    = (x >= box_x_q) && (XW1'(x) < XW1'(box_x_q) + XW1'(BOX_SIZE)) &&
                      (y >= box_y_q) && (YW1'(y) < YW1'(box_y_q) + YW1'(BOX_SIZE));

   assign box_nx    = XW1'(box_x_q) + XW1'(BOX_STEP);
   assign box_ny    = YW1'(box_y_q) + YW1'(BOX_STEP);

   always_comb begin
      mode_d      = mode_q;
      frame_cnt_d = frame_cnt_q;
      box_x_d     = box_x_q;
      box_y_d     = box_y_q;
      dir_x_d     = dir_x_q;
      dir_y_d     = dir_y_q;
      if (frame_start) begin
         mode_d      = mode_e'(mode_sel);
         frame_cnt_d = frame_cnt_q + X_WIDTH'(1);
         // dir = 1 moves towards higher coordinates; clamping keeps the box inside.
         if (dir_x_q) begin
            if (box_nx >= XW1'(HOR_ACTIVE_PIXELS - BOX_SIZE)) begin
               box_x_d = X_WIDTH'(HOR_ACTIVE_PIXELS - BOX_SIZE);
               dir_x_d = 1'b0;
            end else begin
               box_x_d = box_nx[X_WIDTH-1:0];
            end
         end else if (box_x_q <= X_WIDTH'(BOX_STEP)) begin
            box_x_d = '0;
            dir_x_d = 1'b1;
         end else begin
            box_x_d = box_x_q - X_WIDTH'(BOX_STEP);
         end
         if (dir_y_q) begin
            if (box_ny >= YW1'(VER_ACTIVE_PIXELS - BOX_SIZE)) begin
               box_y_d = Y_WIDTH'(VER_ACTIVE_PIXELS - BOX_SIZE);
               dir_y_d = 1'b0;
            end else begin
               box_y_d = box_ny[Y_WIDTH-1:0];
            end
         end else if (box_y_q <= Y_WIDTH'(BOX_STEP)) begin
            box_y_d = '0;
            dir_y_d = 1'b1;
         end else begin
            box_y_d = box_y_q - Y_WIDTH'(BOX_STEP);
         end
      end
   end

   always_comb begin
      r_d = 8'h00;
      g_d = 8'h00;
      b_d = 8'h00;
      case (mode_q)
         MODE_BORDER: begin
            r_d = 8'hFF;
            g_d = on_line ? 8'h00 : 8'hFF;
            b_d = on_line ? 8'h00 : 8'hFF;
         end
         MODE_BARS: begin
            r_d = {8{~bar_idx[1]}};
            g_d = {8{~bar_idx[2]}};
            b_d = {8{~bar_idx[0]}};
         end
         MODE_CHECKER: begin
            r_d = {8{~checker_c}};
            g_d = {8{~checker_c}};
            b_d = {8{~checker_c}};
         end
         MODE_BOX: begin
            g_d = in_box ? 8'hFF : 8'h00;
         end
         default: begin
            r_d = 8'h00;
         end
      endcase
      if (!de) begin
         r_d = 8'h00;
         g_d = 8'h00;
         b_d = 8'h00;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode_q      <= MODE_BORDER;
         frame_cnt_q <= '0;
         box_x_q     <= '0;
         box_y_q     <= '0;
         dir_x_q     <= 1'b1;
         dir_y_q     <= 1'b1;
         r_q         <= 8'h00;
         g_q         <= 8'h00;
         b_q         <= 8'h00;
         de_q        <= 1'b0;
      end else begin
         mode_q      <= mode_d;
         frame_cnt_q <= frame_cnt_d;
         box_x_q     <= box_x_d;
         box_y_q     <= box_y_d;
         dir_x_q     <= dir_x_d;
         dir_y_q     <= dir_y_d;
         r_q         <= r_d;
         g_q         <= g_d;
         b_q         <= b_d;
         de_q        <= de;
      end
   end

   assign r      = r_q;
   assign g      = g_q;
   assign b      = b_q;
   assign de_out = de_q;
   assign mode   = mode_q;

endmodule

// File: tb/tb_video_pattern_gen.sv
// tb/tb_video_pattern_gen.sv - directed and random checks of video_pattern_gen
module tb_video_pattern_gen;
   localparam int HOR  = 640;
   localparam int VER  = 480;
   localparam int BOX  = 32;
   localparam int STEP = 2;
   localparam int CHK  = 5;
   localparam int XW   = $clog2(HOR);
   localparam int YW   = $clog2(VER);

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [XW-1:0] x;
   logic [YW-1:0] y;
   logic          de, frame_start;
   logic [1:0]    mode_sel;
   logic [7:0]    r, g, b;
   logic          de_out;
   logic [1:0]    mode;

   int checks = 0;
   int failures = 0;
   int m_mode, m_fcnt, m_bx, m_by, m_dx, m_dy;
   logic [23:0] bars [8];

   always #5 clk = ~clk;

   video_pattern_gen #(
      .HOR_ACTIVE_PIXELS(HOR), .VER_ACTIVE_PIXELS(VER),
      .BOX_SIZE(BOX), .BOX_STEP(STEP), .CHECKER_LOG2(CHK)
   ) dut (
      .clk(clk), .rst_n(rst_n), .x(x), .y(y), .de(de),
      .frame_start(frame_start), .mode_sel(mode_sel),
      .r(r), .g(g), .b(b), .de_out(de_out), .mode(mode)
   );

   task automatic model_reset();
      m_mode = 0; m_fcnt = 0; m_bx = 0; m_by = 0; m_dx = 1; m_dy = 1;
   endtask

   task automatic step_axis(inout int pos, inout int dir, input int span);
      int nx;
      nx = pos + dir * STEP;
      if (dir == 1 && nx >= span - BOX) begin
         pos = span - BOX; dir = -1;
      end else if (dir == -1 && pos <= STEP) begin
         pos = 0; dir = 1;
      end else begin
         pos = nx;
      end
   endtask

   function automatic logic [23:0] model_pix(input int px, input int py, input bit pde);
      int d1, c;
      if (!pde) return 24'h000000;
      case (m_mode)
         0: begin
            d1 = px * VER / HOR;
            if (px == 0 || px == HOR - 1 || py == 0 || py == VER - 1 || py == d1 || py == VER - d1)
               return 24'hFF0000;
            return 24'hFFFFFF;
         end
         1: return bars[px * 8 / HOR];
         2: begin
            c = ((((px + m_fcnt) % (1 << XW)) >> CHK) + (py >> CHK)) % 2;
            return (c == 1) ? 24'h000000 : 24'hFFFFFF;
         end
         default: begin
            if (px >= m_bx && px < m_bx + BOX && py >= m_by && py < m_by + BOX) return 24'h00FF00;
            return 24'h000000;
         end
      endcase
   endfunction

   task automatic cycle(input int px, input int py, input bit pde, input bit fs, input int msel);
      logic [23:0] exp_pix;
      bit in_rng;
      x = XW'(px); y = YW'(py); de = pde; frame_start = fs; mode_sel = 2'(msel);
      in_rng  = (px < HOR) && (py < VER);
      exp_pix = model_pix(px, py, pde);
      @(posedge clk);
      if (fs) begin
         m_mode = msel;
         m_fcnt = (m_fcnt + 1) % (1 << XW);
         step_axis(m_bx, m_dx, HOR);
         step_axis(m_by, m_dy, VER);
      end
      #1;
      frame_start = 1'b0;
      checks++;
      if (in_rng || !pde) begin
         assert ({r, g, b} === exp_pix) else begin
            failures++;
            $error("FAIL pix x=%0d y=%0d mode=%0d got=%06h exp=%06h", px, py, m_mode, {r, g, b}, exp_pix);
         end
      end else begin
         assert (!$isunknown({r, g, b})) else begin
            failures++;
            $error("FAIL pix_known x=%0d y=%0d got=%06h exp=no X", px, py, {r, g, b});
         end
      end
      checks++;
      assert (de_out === pde) else begin
         failures++;
         $error("FAIL de_out got=%b exp=%b", de_out, pde);
      end
      checks++;
      assert (mode === 2'(m_mode)) else begin
         failures++;
         $error("FAIL mode got=%0d exp=%0d", mode, m_mode);
      end
   endtask

   task automatic check_rgb(input string tag, input logic [23:0] exp_pix);
      checks++;
      assert ({r, g, b} === exp_pix) else begin
         failures++;
         $error("FAIL %s got=%06h exp=%06h", tag, {r, g, b}, exp_pix);
      end
   endtask

   task automatic check_mode(input string tag, input logic [1:0] exp_mode);
      checks++;
      assert (mode === exp_mode) else begin
         failures++;
         $error("FAIL %s got=%0d exp=%0d", tag, mode, exp_mode);
      end
   endtask

   initial begin
      int base;
      bars = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
               24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
      x = '0; y = '0; de = 1'b0; frame_start = 1'b0; mode_sel = 2'd0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      checks++;
      assert ({r, g, b, de_out, mode} === 27'd0) else begin
         failures++;
         $error("FAIL reset got=%07h exp=0", {r, g, b, de_out, mode});
      end
      rst_n = 1'b1;

      cycle(0, 0, 1, 0, 0);     check_rgb("m0_origin", 24'hFF0000);
      cycle(100, 50, 1, 0, 0);  check_rgb("m0_inner", 24'hFFFFFF);
      cycle(100, 75, 1, 0, 0);  check_rgb("m0_diag", 24'hFF0000);
      cycle(639, 200, 1, 0, 0); check_rgb("m0_right", 24'hFF0000);
      cycle(160, 360, 1, 0, 0); check_rgb("m0_anti", 24'hFF0000);
      cycle(160, 121, 1, 0, 0); check_rgb("m0_off_diag", 24'hFFFFFF);
      cycle(5, 5, 0, 0, 0);     check_rgb("de_low", 24'h000000);

      cycle(0, 0, 0, 1, 1);
      check_mode("mode_to_1", 2'd1);
      for (int i = 0; i < 8; i++) begin
         cycle(i * 80, 10, 1, 0, 0);
         check_rgb($sformatf("bar%0d", i), bars[i]);
      end
      cycle(79, 10, 1, 0, 0);   check_rgb("bar_edge", 24'hFFFFFF);

      cycle(0, 0, 0, 1, 2);
      repeat (5) cycle(int'($urandom_range(0, HOR - 1)), 7, 1, 0, 3);
      check_mode("mode_held", 2'd2);

      base = ((31 - m_fcnt) % (1 << XW) + (1 << XW)) % (1 << XW);
      cycle(base, 0, 1, 0, 2);     check_rgb("chk_white", 24'hFFFFFF);
      cycle(base + 1, 0, 1, 0, 2); check_rgb("chk_black", 24'h000000);
      cycle(0, 0, 0, 1, 2);
      cycle(base, 0, 1, 0, 2);     check_rgb("chk_scroll", 24'h000000);

      base = ((31 - m_fcnt) % (1 << XW) + (1 << XW)) % (1 << XW);
      cycle(base, 0, 1, 1, 3);     check_rgb("fs_same_cycle", 24'hFFFFFF);
      check_mode("mode_to_3", 2'd3);

      for (int k = 0; k < 3000; k++) begin
         int px, py, msel;
         bit pde, fs;
         fs   = ($urandom_range(0, 39) == 0);
         msel = int'($urandom_range(0, 3));
         pde  = ($urandom_range(0, 3) != 0);
         if (m_mode == 3 && $urandom_range(0, 1) == 1) begin
            px = m_bx + int'($urandom_range(0, 39)) - 4;
            py = m_by + int'($urandom_range(0, 39)) - 4;
            if (px < 0) px = 0;
            if (py < 0) py = 0;
         end else begin
            px = ($urandom_range(0, 15) == 0) ? int'($urandom_range(HOR, (1 << XW) - 1))
                                              : int'($urandom_range(0, HOR - 1));
            py = ($urandom_range(0, 15) == 0) ? int'($urandom_range(VER, (1 << YW) - 1))
                                              : int'($urandom_range(0, VER - 1));
         end
         cycle(px, py, pde, fs, msel);
      end

      cycle(0, 0, 0, 1, 1);
      cycle(1, 1, 1, 0, 1);
      rst_n = 1'b0;
      #1;
      checks++;
      assert ({r, g, b, de_out, mode} === 27'd0) else begin
         failures++;
         $error("FAIL async_reset got=%07h exp=0", {r, g, b, de_out, mode});
      end
      #1;
      rst_n = 1'b1;
      model_reset();
      cycle(0, 0, 0, 0, 0);     check_rgb("post_reset_idle", 24'h000000);
      cycle(0, 5, 1, 0, 0);     check_rgb("post_reset_m0", 24'hFF0000);

      repeat (10) cycle(0, 0, 0, 1, 3);
      cycle(20, 20, 1, 0, 3);   check_rgb("box_corner", 24'h00FF00);
      cycle(52, 20, 1, 0, 3);   check_rgb("box_right_out", 24'h000000);
      cycle(19, 20, 1, 0, 3);   check_rgb("box_left_out", 24'h000000);
      cycle(51, 51, 1, 0, 3);   check_rgb("box_far", 24'h00FF00);

      for (int k = 0; k < 400 && m_bx != HOR - BOX; k++) cycle(0, 0, 0, 1, 3);
      cycle(HOR - BOX, m_by, 1, 0, 3);     check_rgb("box_at_max", 24'h00FF00);
      cycle(HOR - 1, m_by, 1, 0, 3);       check_rgb("box_max_edge", 24'h00FF00);
      cycle(HOR - BOX - 1, m_by, 1, 0, 3); check_rgb("box_max_out", 24'h000000);
      for (int k = 0; k < 400 && m_bx != 0; k++) cycle(0, 0, 0, 1, 3);
      cycle(0, m_by, 1, 0, 3);   check_rgb("box_at_zero", 24'h00FF00);
      cycle(31, m_by, 1, 0, 3);  check_rgb("box_zero_edge", 24'h00FF00);
      cycle(32, m_by, 1, 0, 3);  check_rgb("box_zero_out", 24'h000000);
      cycle(0, 0, 0, 1, 3);
      cycle(1, m_by, 1, 0, 3);   check_rgb("box_rebound_out", 24'h000000);
      cycle(2, m_by, 1, 0, 3);   check_rgb("box_rebound_in", 24'h00FF00);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/video_pattern_gen.md
Name: video_pattern_gen

Overview:
- Parametrised, registered successor to the static border/diagonal test-pattern block.
- Sits between the video timing generator and the video output encoder.
- Produces one of four selectable test patterns, two of them animated per frame.
- Mode changes take effect only at frame boundaries.

Parameters:
HOR_ACTIVE_PIXELS, 640, active pixels per line; X_WIDTH = $clog2(HOR_ACTIVE_PIXELS)
VER_ACTIVE_PIXELS, 480, active lines per frame; Y_WIDTH = $clog2(VER_ACTIVE_PIXELS)
BOX_SIZE, 32, side in pixels of the bouncing box (mode 3); must be < both active dimensions
BOX_STEP, 2, box displacement per frame per axis, in pixels; must be >= 1
CHECKER_LOG2, 5, log2 of checker square size in pixels (mode 2)

Ports:
clk  input  1  pixel clock
rst_n  input  1  reset, asynchronous assert, active-low
x  input  X_WIDTH  current pixel column
y  input  Y_WIDTH  current pixel row
de  input  1  high when x/y address an active pixel
frame_start  input  1  one-cycle pulse, asserted during vertical blanking before pixel (0,0)
mode_sel  input  2  requested pattern, sampled only on frame_start
r  output  8  red, registered
g  output  8  green, registered
b  output  8  blue, registered
de_out  output  1  de delayed one cycle, aligned with r/g/b
mode  output  2  currently active pattern

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset values: r=g=b=0, de_out=0, mode=0, frame_cnt=0, box_x=box_y=0, dir_x=dir_y=+1.
- Latency: r/g/b/de_out reflect the x/y/de presented one cycle earlier.
- When de=0, next r=g=b=0.
- frame_start cycle:
  - mode <= mode_sel.
  - frame_cnt (X_WIDTH bits) increments, wrapping at 2^X_WIDTH.
  - Box position updates as described under mode 3.
  - The pixel sampled in that same cycle uses the pre-update state.
- mode_sel changes between frame_start pulses have no effect.
- Mode 0, border/diagonal:
  - r=255.
  - g=b=0 if x==0, x==HOR_ACTIVE_PIXELS-1, y==0, y==VER_ACTIVE_PIXELS-1, y==x*VER_ACTIVE_PIXELS/HOR_ACTIVE_PIXELS, or y==VER_ACTIVE_PIXELS-x*VER_ACTIVE_PIXELS/HOR_ACTIVE_PIXELS.
  - Otherwise g=b=255.
  - Products are computed at X_WIDTH+Y_WIDTH bits with truncating integer division.
- Mode 1, colour bars:
  - i = x*8/HOR_ACTIVE_PIXELS (3 bits).
  - r=255 if i[1]==0 else 0; g=255 if i[2]==0 else 0; b=255 if i[0]==0 else 0.
  - Resulting sequence: white, yellow, cyan, green, magenta, red, blue, black.
- Mode 2, scrolling checker:
  - c = ((x+frame_cnt) mod 2^X_WIDTH)[CHECKER_LOG2] XOR y[CHECKER_LOG2].
  - c=0 gives white (255,255,255); c=1 gives black.
  - The pattern scrolls left by one pixel per frame.
- Mode 3, bouncing box:
  - Pixels with box_x <= x < box_x+BOX_SIZE and box_y <= y < box_y+BOX_SIZE are green (0,255,0); all others black.
  - Update per frame_start, per axis (X shown; Y is analogous with VER_ACTIVE_PIXELS):
    - nx = box_x + dir_x*BOX_STEP.
    - If dir_x=+1 and nx >= HOR_ACTIVE_PIXELS-BOX_SIZE: box_x <= HOR_ACTIVE_PIXELS-BOX_SIZE, dir_x <= -1.
    - If dir_x=-1 and box_x <= BOX_STEP: box_x <= 0, dir_x <= +1.
    - Otherwise box_x <= nx.
  - The box never leaves the active area, with no underflow or wrap.
  - Box state advances on every frame_start regardless of mode.
- Reset mid-frame: all state returns to reset values immediately; outputs are 0 until the cycle after de is sampled high post-reset.
- Out-of-range x/y (>= active size) with de=1: pattern math is still evaluated; no requirement on colour, but there must be no X/undefined outputs.

Test Plan:
- Reset, then de=1, x=0,y=0, mode 0 -> next cycle r=255,g=0,b=0,de_out=1; x=100,y=50 (640x480) -> (255,255,255); x=100,y=75 (diagonal) -> (255,0,0).
- mode_sel=1 with frame_start, then x=0,80,160,...,560 -> colours white, yellow, cyan, green, magenta, red, blue, black, one cycle later.
- mode_sel=2 changed to 3 mid-frame, no frame_start -> mode stays 2; on the next frame_start -> mode=3 and the same-cycle pixel still uses mode 2.
- Mode 2, CHECKER_LOG2=5: frame_cnt=0, (x=31,y=0) white, (x=32,y=0) black; after one frame_start, (x=31,y=0) is black.
- Mode 3, defaults: after 10 frame_starts box_x=box_y=20; pixel (20,20) green, (52,20) black; X reverses at box_x=608 and returns to exactly 0 without underflow.
- Drop rst_n for 1 cycle mid-frame -> r/g/b/de_out/mode/box immediately zero/reset, asynchronously, before the next clk edge.
